// File: rtl/aw_w_beat_sequencer.sv
// AW/W beat sequencer: pops the AW pending FIFO head and walks the W burst.
// Ports: ACLK/ARESETn; fifo_* + front_AW* (AW FIFO); S_W*/M_W* (W handshake);
//   beat_addr/beat_id (current beat); wlast_err/burst_err (1-cycle pulses).
module aw_w_beat_sequencer #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [ID_WIDTH-1:0]   front_AWID,
  input  logic [ADDR_WIDTH-1:0] front_AWADDR,
  input  logic [LEN_WIDTH-1:0]  front_AWLEN,
  input  logic [SIZE_WIDTH-1:0] front_AWSIZE,
  input  logic [1:0]            front_AWBURST,
  input  logic                  S_WVALID,
  input  logic                  S_WLAST,
  output logic                  S_WREADY,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  output logic                  M_WLAST,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic                  wlast_err,
  output logic                  burst_err
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [1:0]            burst_q;

  logic                  in_burst;
  logic                  hs;
  logic                  last;
  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wsz;
  logic [ADDR_WIDTH-1:0] lo;
  logic [ADDR_WIDTH-1:0] nxt;

  assign in_burst  = (state == BURST);
  assign hs        = in_burst & S_WVALID & M_WREADY;
  assign last      = in_burst & (beat_cnt == len_q);

  assign M_WVALID  = in_burst & S_WVALID;
  assign S_WREADY  = in_burst & M_WREADY;
  assign M_WLAST   = last;
  assign fifo_pop  = hs & last;
  assign wlast_err = hs & (S_WLAST != last);
  assign burst_err = (state == IDLE) & ~fifo_empty
                   & (front_AWBURST == 2'b11);
  assign beat_addr = addr_q;
  assign beat_id   = id_q;

  // Wrap window is (len+1) beats wide; len is 1/3/7/15 for legal WRAP.
  assign bytes   = ADDR_WIDTH'(1) << size_q;
  assign aligned = addr_q & ~(bytes - ADDR_WIDTH'(1));
  assign incr    = aligned + bytes;
  assign wsz     = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
  assign lo      = addr_q & ~(wsz - ADDR_WIDTH'(1));

  always_comb begin
    nxt = incr;
    unique case (burst_q)
      2'b00:   nxt = addr_q;
      2'b10:   nxt = (incr == lo + wsz) ? lo : incr;
      default: nxt = incr;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      size_q   <= '0;
      burst_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= BURST;
            id_q     <= front_AWID;
            addr_q   <= front_AWADDR;
            len_q    <= front_AWLEN;
            size_q   <= front_AWSIZE;
            burst_q  <= front_AWBURST;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (hs) begin
            if (last) begin
              // Clear so beat_addr/beat_id read 0 while idle.
              state    <= IDLE;
              id_q     <= '0;
              addr_q   <= '0;
              len_q    <= '0;
              size_q   <= '0;
              burst_q  <= '0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
              addr_q   <= nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aw_w_beat_sequencer.sv
// Bench for aw_w_beat_sequencer: burst-level model checked every cycle,
// plus literal per-beat expectations for each directed burst.
module tb_aw_w_beat_sequencer;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ent_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic        last;
    logic        pop;
    logic        werr;
    int          cyc;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [3:0]  front_AWID;
  logic [31:0] front_AWADDR;
  logic [3:0]  front_AWLEN;
  logic [2:0]  front_AWSIZE;
  logic [1:0]  front_AWBURST;
  logic        S_WVALID;
  logic        S_WLAST;
  logic        S_WREADY;
  logic        M_WVALID;
  logic        M_WREADY;
  logic        M_WLAST;
  logic [31:0] beat_addr;
  logic [3:0]  beat_id;
  logic        wlast_err;
  logic        burst_err;

  aw_w_beat_sequencer dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .front_AWID(front_AWID), .front_AWADDR(front_AWADDR),
    .front_AWLEN(front_AWLEN), .front_AWSIZE(front_AWSIZE),
    .front_AWBURST(front_AWBURST),
    .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WLAST(M_WLAST),
    .beat_addr(beat_addr), .beat_id(beat_id),
    .wlast_err(wlast_err), .burst_err(burst_err)
  );

  always #5 ACLK = ~ACLK;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    berr_cnt = 0;
  ent_t  fq[$];
  beat_t log_q[$];

  logic  m_busy = 1'b0;
  ent_t  m_cur;
  int    m_k = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    if (fq.size() != 0) begin
      front_AWID    = fq[0].id;
      front_AWADDR  = fq[0].addr;
      front_AWLEN   = fq[0].len;
      front_AWSIZE  = fq[0].size;
      front_AWBURST = fq[0].burst;
    end else begin
      front_AWID    = '0;
      front_AWADDR  = '0;
      front_AWLEN   = '0;
      front_AWSIZE  = '0;
      front_AWBURST = '0;
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] a,
                      input logic [3:0] l, input logic [2:0] s,
                      input logic [1:0] b);
    ent_t e;
    e.id = id; e.addr = a; e.len = l; e.size = s; e.burst = b;
    fq.push_back(e);
    refresh();
  endtask

  // Address of beat k straight from the burst definition.
  function automatic logic [31:0] addr_of(input ent_t e, input int k);
    logic [31:0] b, al, wsz, lo;
    b   = 32'd1 << e.size;
    al  = e.addr - (e.addr % b);
    wsz = (32'(e.len) + 32'd1) * b;
    lo  = e.addr - (e.addr % wsz);
    if (k == 0 || e.burst == 2'b00) return e.addr;
    if (e.burst == 2'b10) return lo + ((al - lo + 32'(k) * b) % wsz);
    return al + 32'(k) * b;
  endfunction

  // Environment FIFO: pops on the sequencer's request, shares reset.
  initial begin
    logic p, r;
    forever begin
      @(negedge ACLK);
      p = fifo_pop & ARESETn;
      r = ~ARESETn;
      @(posedge ACLK);
      #1;
      if (r) fq.delete();
      else if (p && fq.size() != 0) void'(fq.pop_front());
      refresh();
    end
  end

  // Compare process: model expectations every cycle out of reset.
  initial begin
    logic hs, e_last;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (burst_err === 1'b1) berr_cnt++;
      if (!ARESETn) begin
        m_busy = 1'b0;
      end else begin
        hs     = m_busy & S_WVALID & M_WREADY;
        e_last = m_busy && (m_k == int'(m_cur.len));
        chk("M_WVALID", 32'(M_WVALID), 32'(m_busy & S_WVALID));
        chk("S_WREADY", 32'(S_WREADY), 32'(m_busy & M_WREADY));
        chk("M_WLAST", 32'(M_WLAST), 32'(e_last));
        chk("beat_addr", beat_addr, m_busy ? addr_of(m_cur, m_k) : 32'd0);
        chk("beat_id", 32'(beat_id), m_busy ? 32'(m_cur.id) : 32'd0);
        chk("fifo_pop", 32'(fifo_pop), 32'(hs & e_last));
        chk("wlast_err", 32'(wlast_err), 32'(hs & (S_WLAST != e_last)));
        chk("burst_err", 32'(burst_err),
            32'(!m_busy && fq.size() != 0 && front_AWBURST == 2'b11));
        if (hs)
          log_q.push_back('{beat_addr, beat_id, M_WLAST, fifo_pop,
                            wlast_err, cyc});
        if (!m_busy) begin
          if (fq.size() != 0) begin
            m_cur  = fq[0];
            m_k    = 0;
            m_busy = 1'b1;
          end
        end else if (hs) begin
          if (e_last) m_busy = 1'b0;
          else m_k++;
        end
      end
    end
  end

  task automatic step(input logic v, input logic r, input logic l);
    S_WVALID = v;
    M_WREADY = r;
    S_WLAST  = l;
    @(posedge ACLK);
    #2;
  endtask

  task automatic chk_addrs(input string nm, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input int n);
    logic [31:0] ex [4];
    ex[0] = a0; ex[1] = a1; ex[2] = a2; ex[3] = a3;
    chk({nm, "_beats"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk({nm, "_addr"}, log_q[i].addr, ex[i]);
  endtask

  function automatic int pops();
    int c = 0;
    foreach (log_q[i]) c += int'(log_q[i].pop);
    return c;
  endfunction

  function automatic int werrs();
    int c = 0;
    foreach (log_q[i]) c += int'(log_q[i].werr);
    return c;
  endfunction

  initial begin
    ARESETn  = 1'b0;
    S_WVALID = 1'b0;
    S_WLAST  = 1'b0;
    M_WREADY = 1'b0;
    refresh();
    repeat (3) @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
    step(0, 0, 0);
    chk("rst_addr", beat_addr, 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_valid", 32'(M_WVALID), 32'd0);

    // INCR 0x1000 len=3 size=2
    log_q.delete();
    push(4'd1, 32'h1000, 4'd3, 3'd2, 2'b01);
    repeat (4) step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk_addrs("incr", 32'h1000, 32'h1004, 32'h1008, 32'h100C, 4);
    if (log_q.size() == 4) begin
      chk("incr_last0", 32'(log_q[0].last), 32'd0);
      chk("incr_last3", 32'(log_q[3].last), 32'd1);
      chk("incr_pop3", 32'(log_q[3].pop), 32'd1);
    end
    chk("incr_pops", 32'(pops()), 32'd1);

    // WRAP 0x1008 len=3 size=2
    log_q.delete();
    push(4'd2, 32'h1008, 4'd3, 3'd2, 2'b10);
    repeat (4) step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk_addrs("wrap", 32'h1008, 32'h100C, 32'h1000, 32'h1004, 4);
    chk("wrap_werr", 32'(werrs()), 32'd0);

    // FIXED 0x20 len=2 with a 3-cycle M_WREADY stall
    log_q.delete();
    push(4'd4, 32'h20, 4'd2, 3'd2, 2'b00);
    step(1, 1, 0);
    step(1, 1, 0);
    repeat (3) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk_addrs("fixed", 32'h20, 32'h20, 32'h20, 32'h0, 3);
    chk("fixed_pops", 32'(pops()), 32'd1);

    // len=1 with an early S_WLAST
    log_q.delete();
    push(4'd6, 32'h40, 4'd1, 3'd2, 2'b01);
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 1);
    step(0, 0, 0);
    chk("wl_beats", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("wl_werr0", 32'(log_q[0].werr), 32'd1);
      chk("wl_werr1", 32'(log_q[1].werr), 32'd0);
      chk("wl_last1", 32'(log_q[1].last), 32'd1);
      chk("wl_pop0", 32'(log_q[0].pop), 32'd0);
      chk("wl_pop1", 32'(log_q[1].pop), 32'd1);
    end

    // Back-to-back entries
    log_q.delete();
    push(4'd3, 32'h100, 4'd1, 3'd0, 2'b01);
    push(4'd5, 32'h200, 4'd0, 3'd1, 2'b01);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk_addrs("b2b", 32'h100, 32'h101, 32'h200, 32'h0, 3);
    if (log_q.size() == 3) begin
      chk("b2b_id0", 32'(log_q[0].id), 32'd3);
      chk("b2b_id2", 32'(log_q[2].id), 32'd5);
      chk("b2b_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
    end
    chk("b2b_pops", 32'(pops()), 32'd2);

    // Reserved burst type, unaligned start
    log_q.delete();
    berr_cnt = 0;
    push(4'd7, 32'h1002, 4'd1, 3'd2, 2'b11);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk_addrs("rsvd", 32'h1002, 32'h1004, 32'h0, 32'h0, 2);
    chk("rsvd_berr", 32'(berr_cnt), 32'd1);

    // Reset on beat 2 of 4
    log_q.delete();
    push(4'd8, 32'h3000, 4'd3, 3'd2, 2'b01);
    step(1, 1, 0);
    step(1, 1, 0);
    ARESETn = 1'b0;
    step(1, 1, 0);
    ARESETn = 1'b1;
    chk("rst_mid_addr", beat_addr, 32'd0);
    chk("rst_mid_id", 32'(beat_id), 32'd0);
    chk("rst_mid_valid", 32'(M_WVALID), 32'd0);
    chk("rst_mid_last", 32'(M_WLAST), 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_mid_beats", 32'(log_q.size()), 32'd1);
    chk("rst_mid_pops", 32'(pops()), 32'd0);
    chk("rst_mid_fifo", 32'(fq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
